change_dispenser: RTL

- Downstream of vending_machine: converts the change amount (cents) owed after a vend or cancel into coin-return counts.
- Counts cover $5, $1, quarter, dime and nickel, and feed the boardChange display and the boardChangeFive LED.
- Greedy, one coin per clock, with a start/busy/done handshake.

---
 rtl/vm_pkg.sv | 24 ++
 rtl/coin_select.sv | 37 +++
 rtl/change_dispenser.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine change path: coin values,
// coin_pulse bit positions and the change-dispenser state encoding.
package vm_pkg;

    localparam int COIN_FIVE    = 500;
    localparam int COIN_DOLLAR  = 100;
    localparam int COIN_QUARTER = 25;
    localparam int COIN_DIME    = 10;
    localparam int COIN_NICKEL  = 5;

    localparam int NUM_COINS    = 5;
    localparam int BIT_NICKEL   = 0;
    localparam int BIT_DIME     = 1;
    localparam int BIT_QUARTER  = 2;
    localparam int BIT_DOLLAR   = 3;
    localparam int BIT_FIVE     = 4;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

endpackage

// File: rtl/coin_select.sv
// Combinational largest-eligible-coin picker. A coin is eligible when its
// value fits in the remaining amount and its stockOk bit is set. Outputs a
// one-hot select (all zero when nothing fits) and the chosen coin value.
module coin_select
    import vm_pkg::*;
#(
    parameter int CHANGE_W = 11
) (
    input  logic [CHANGE_W-1:0]  rem,
    input  logic [NUM_COINS-1:0] stockOk,
    output logic [NUM_COINS-1:0] sel,
    output logic [CHANGE_W-1:0]  value
);

    // Priority search from the largest denomination down
    always_comb begin
        sel   = '0;
        value = '0;
        if (stockOk[BIT_FIVE] && rem >= CHANGE_W'(COIN_FIVE)) begin
            sel[BIT_FIVE] = 1'b1;
            value         = CHANGE_W'(COIN_FIVE);
        end else if (stockOk[BIT_DOLLAR] && rem >= CHANGE_W'(COIN_DOLLAR)) begin
            sel[BIT_DOLLAR] = 1'b1;
            value           = CHANGE_W'(COIN_DOLLAR);
        end else if (stockOk[BIT_QUARTER] && rem >= CHANGE_W'(COIN_QUARTER)) begin
            sel[BIT_QUARTER] = 1'b1;
            value            = CHANGE_W'(COIN_QUARTER);
        end else if (stockOk[BIT_DIME] && rem >= CHANGE_W'(COIN_DIME)) begin
            sel[BIT_DIME] = 1'b1;
            value         = CHANGE_W'(COIN_DIME);
        end else if (stockOk[BIT_NICKEL] && rem >= CHANGE_W'(COIN_NICKEL)) begin
            sel[BIT_NICKEL] = 1'b1;
            value           = CHANGE_W'(COIN_NICKEL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: converts a cent amount into coin-return counts,
// one coin per clock, with a start/busy/done handshake.
// Optional feature macro COIN_STOCK_EN: finite per-coin stock with restock,
// and shortfall reporting when the stock cannot cover the amount.
// The first coin is chosen directly from change_cents on the accepting edge,
// so its pulse appears in the first busy cycle; rem then holds the amount
// still owed after the coins already pulsed.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int CHANGE_W   = 11,
    parameter int CNT_W      = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHANGE_W-1:0]  change_cents,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_COINS-1:0] coin_pulse,
    output logic [CNT_W-1:0]     cnt_five,
    output logic [CNT_W-1:0]     cnt_dollar,
    output logic [CNT_W-1:0]     cnt_quarter,
    output logic [CNT_W-1:0]     cnt_dime,
    output logic [CNT_W-1:0]     cnt_nickel,
    output logic [CHANGE_W-1:0]  shortfall
`ifdef COIN_STOCK_EN
    ,
    input  logic                 restock
`endif
);

    state_t               state;
    logic [CHANGE_W-1:0]  rem;
    logic [CHANGE_W-1:0]  pickIn;
    logic [CHANGE_W-1:0]  coinValue;
    logic [NUM_COINS-1:0] coinSel;
    logic [NUM_COINS-1:0] stockOk;
    logic [CNT_W-1:0]     cnt [NUM_COINS];
    logic                 badAmount;
    logic                 takeCoin;

    if (INIT_STOCK >= (1 << CNT_W)) begin : gBadInitStock
        $error("INIT_STOCK does not fit in CNT_W bits");
    end

    assign busy        = (state != IDLE);
    assign badAmount   = (change_cents % CHANGE_W'(5)) != '0;
    assign pickIn      = (state == IDLE) ? change_cents : rem;
    assign takeCoin    = (((state == IDLE) && start && !badAmount) || (state == DISPENSE))
                         && (coinSel != '0);

    assign cnt_five    = cnt[BIT_FIVE];
    assign cnt_dollar  = cnt[BIT_DOLLAR];
    assign cnt_quarter = cnt[BIT_QUARTER];
    assign cnt_dime    = cnt[BIT_DIME];
    assign cnt_nickel  = cnt[BIT_NICKEL];

`ifdef COIN_STOCK_EN
    logic [CNT_W-1:0]    stock [NUM_COINS];
    logic [CHANGE_W-1:0] shortfallReg;

    for (genvar g = 0; g < NUM_COINS; g++) begin : gStockOk
        assign stockOk[g] = (stock[g] != '0);
    end
    assign shortfall = shortfallReg;

    // Stock counters: reload wins over a same-cycle dispense
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            for (int i = 0; i < NUM_COINS; i++) stock[i] <= CNT_W'(INIT_STOCK);
        end else if (takeCoin) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (coinSel[i]) stock[i] <= stock[i] - CNT_W'(1);
            end
        end
    end
`else
    assign stockOk   = '1;
    assign shortfall = '0;
`endif

    coin_select #(
        .CHANGE_W (CHANGE_W)
    ) uCoinSelect (
        .rem     (pickIn),
        .stockOk (stockOk),
        .sel     (coinSel),
        .value   (coinValue)
    );

    // Control FSM with registered done/error/coin_pulse and per-coin counts
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            coin_pulse <= '0;
            for (int i = 0; i < NUM_COINS; i++) cnt[i] <= '0;
`ifdef COIN_STOCK_EN
            shortfallReg <= '0;
`endif
        end else begin
            done       <= 1'b0;
            error      <= 1'b0;
            coin_pulse <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef COIN_STOCK_EN
                        shortfallReg <= '0;
`endif
                        if (badAmount) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                            for (int i = 0; i < NUM_COINS; i++) cnt[i] <= '0;
                        end else if (takeCoin) begin
                            state      <= DISPENSE;
                            rem        <= change_cents - coinValue;
                            coin_pulse <= coinSel;
                            for (int i = 0; i < NUM_COINS; i++) cnt[i] <= CNT_W'(coinSel[i]);
                        end else begin
                            // Zero amount, or nothing in stock for a nonzero amount
                            state <= DONE;
                            done  <= 1'b1;
                            for (int i = 0; i < NUM_COINS; i++) cnt[i] <= '0;
`ifdef COIN_STOCK_EN
                            shortfallReg <= change_cents;
`endif
                        end
                    end
                end
                DISPENSE: begin
                    if (takeCoin) begin
                        rem        <= rem - coinValue;
                        coin_pulse <= coinSel;
                        for (int i = 0; i < NUM_COINS; i++) cnt[i] <= cnt[i] + CNT_W'(coinSel[i]);
                    end else begin
                        // rem is zero here unless stock ran out
                        state <= DONE;
                        done  <= 1'b1;
`ifdef COIN_STOCK_EN
                        shortfallReg <= rem;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
